// File: rtl/dram_write_merger_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dram_write_merger_pkg
// Purpose  : Shared configuration defaults and merger state encoding.
// Revision : 1.0
// ============================================================================
package dram_write_merger_pkg;

  localparam int c_global_addr_bw      = 32;
  localparam int c_data_bw             = 32;
  localparam int c_cache_size          = 8;
  localparam int c_dramw_merge_timeout = 8;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_COLLECT = 2'd1,
    ST_ISSUE   = 2'd2
  } merge_state_e;

endpackage
`default_nettype wire

// File: rtl/dram_write_merger_line_merge.sv
`default_nettype none
// ============================================================================
// Module   : dram_line_merge
// Purpose  : Word-masked overlay of a new partial line onto a staged line.
// Revision : 1.0
// ============================================================================
module dram_line_merge
  import dram_write_merger_pkg::*;
#(
  parameter int DBW   = c_data_bw,
  parameter int CSIZE = c_cache_size
) (
  input  logic [CSIZE-1:0][DBW-1:0] i_old_data,
  input  logic [CSIZE-1:0]          i_old_mask,
  input  logic [CSIZE-1:0][DBW-1:0] i_new_data,
  input  logic [CSIZE-1:0]          i_new_mask,
  output logic [CSIZE-1:0][DBW-1:0] o_data,
  output logic [CSIZE-1:0]          o_mask,
  output logic                      o_full
);

  for (genvar k = 0; k < CSIZE; k++) begin : g_word
    assign o_data[k] = i_new_mask[k] ? i_new_data[k] : i_old_data[k];
  end

  assign o_mask = i_old_mask | i_new_mask;
  assign o_full = &o_mask;

endmodule
`default_nettype wire

// File: rtl/dram_write_merger.sv
`default_nettype none
// ============================================================================
// Module   : dram_write_merger
// Purpose  : Merges consecutive same-line partial writes into one DRAM write.
//            Optional counters o_n_merge/o_n_issue under DRAMW_MERGE_STAT_EN.
// Revision : 1.0
// ============================================================================
module dram_write_merger
  import dram_write_merger_pkg::*;
#(
  parameter int GBW     = c_global_addr_bw,
  parameter int DBW     = c_data_bw,
  parameter int CSIZE   = c_cache_size,
  parameter int TIMEOUT = c_dramw_merge_timeout
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      wi_rdy,
  output logic                      wi_ack,
  input  logic [GBW-1:0]            i_dramwa,
  input  logic [CSIZE-1:0][DBW-1:0] i_dramwd,
  input  logic [CSIZE-1:0]          i_dramw_mask,
  input  logic                      i_flush,
  output logic                      dramw_rdy,
  input  logic                      dramw_ack,
  output logic [GBW-1:0]            o_dramwa,
  output logic [CSIZE-1:0][DBW-1:0] o_dramwd,
  output logic [CSIZE-1:0]          o_dramw_mask,
  output logic                      o_idle
`ifdef DRAMW_MERGE_STAT_EN
  ,
  output logic [31:0]               o_n_merge,
  output logic [31:0]               o_n_issue
`endif
);

  localparam int                 c_tmr_w   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [c_tmr_w-1:0] c_timeout = c_tmr_w'(TIMEOUT);

  merge_state_e              r_state;
  logic [GBW-1:0]            r_addr;
  logic [CSIZE-1:0][DBW-1:0] r_data;
  logic [CSIZE-1:0]          r_mask;
  logic [c_tmr_w-1:0]        r_timer;

  logic                      w_collect;
  logic                      w_same_addr;
  logic                      w_in_nz;
  logic                      w_mrg_full;
  logic [CSIZE-1:0][DBW-1:0] w_old_data;
  logic [CSIZE-1:0][DBW-1:0] w_mrg_data;
  logic [CSIZE-1:0]          w_old_mask;
  logic [CSIZE-1:0]          w_mrg_mask;

  assign w_collect   = (r_state == ST_COLLECT);
  assign w_same_addr = (i_dramwa == r_addr);
  assign w_in_nz     = |i_dramw_mask;

  // A fresh capture overlays an empty line, so unmasked words of a new entry are zero.
  assign w_old_data = w_collect ? r_data : '0;
  assign w_old_mask = w_collect ? r_mask : '0;

  dram_line_merge #(
    .DBW   (DBW),
    .CSIZE (CSIZE)
  ) u_line_merge (
    .i_old_data (w_old_data),
    .i_old_mask (w_old_mask),
    .i_new_data (i_dramwd),
    .i_new_mask (i_dramw_mask),
    .o_data     (w_mrg_data),
    .o_mask     (w_mrg_mask),
    .o_full     (w_mrg_full)
  );

  always_comb begin
    wi_ack = 1'b0;
    if (!i_rst) begin
      case (r_state)
        ST_EMPTY:   wi_ack = wi_rdy;
        ST_COLLECT: wi_ack = wi_rdy && w_same_addr;
        ST_ISSUE:   wi_ack = wi_rdy && dramw_ack;
        default:    wi_ack = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_EMPTY;
      r_addr  <= '0;
      r_data  <= '0;
      r_mask  <= '0;
      r_timer <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (wi_rdy && w_in_nz) begin
            r_addr  <= i_dramwa;
            r_data  <= w_mrg_data;
            r_mask  <= w_mrg_mask;
            r_timer <= '0;
            r_state <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (wi_rdy && w_same_addr) begin
            r_data  <= w_mrg_data;
            r_mask  <= w_mrg_mask;
            r_timer <= '0;
            if (w_mrg_full || i_flush) r_state <= ST_ISSUE;
          end else if (wi_rdy || i_flush || (&r_mask) || (r_timer == c_timeout)) begin
            r_state <= ST_ISSUE;
          end else begin
            r_timer <= r_timer + c_tmr_w'(1);
          end
        end
        ST_ISSUE: begin
          // The entry stays frozen until DRAM takes it; a waiting input refills it in the same cycle.
          if (dramw_ack) begin
            if (wi_rdy && w_in_nz) begin
              r_addr  <= i_dramwa;
              r_data  <= w_mrg_data;
              r_mask  <= w_mrg_mask;
              r_timer <= '0;
              r_state <= ST_COLLECT;
            end else begin
              r_mask  <= '0;
              r_state <= ST_EMPTY;
            end
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  assign dramw_rdy    = (r_state == ST_ISSUE);
  assign o_dramwa     = r_addr;
  assign o_dramwd     = r_data;
  assign o_dramw_mask = r_mask;
  assign o_idle       = (r_state == ST_EMPTY);

`ifdef DRAMW_MERGE_STAT_EN
  logic [31:0] r_n_merge;
  logic [31:0] r_n_issue;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_n_merge <= '0;
      r_n_issue <= '0;
    end else begin
      if (w_collect && wi_ack)     r_n_merge <= r_n_merge + 32'd1;
      if (dramw_rdy && dramw_ack)  r_n_issue <= r_n_issue + 32'd1;
    end
  end

  assign o_n_merge = r_n_merge;
  assign o_n_issue = r_n_issue;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dram_write_merger.sv
`default_nettype none
// ============================================================================
// Module   : tb_dram_write_merger
// Purpose  : Vector table, directed corner sequences and randomized traffic
//            against a line-level reference model. Honours DRAMW_MERGE_STAT_EN.
// Revision : 1.0
// ============================================================================
module tb_dram_write_merger;
  import dram_write_merger_pkg::*;

  localparam int GBW = 16;
  localparam int DBW = 16;
  localparam int CSIZE = 8;
  localparam int TIMEOUT = 4;

  typedef logic [CSIZE-1:0][DBW-1:0] line_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wi_rdy = 1'b0;
  logic        wi_ack;
  logic [15:0] dramwa = '0;
  line_t       dramwd = '0;
  logic [7:0]  dramw_mask = '0;
  logic        flush = 1'b0;
  logic        dramw_rdy;
  logic        dramw_ack = 1'b0;
  logic [15:0] o_addr;
  line_t       o_data;
  logic [7:0]  o_mask;
  logic        o_idle;
`ifdef DRAMW_MERGE_STAT_EN
  logic [31:0] n_merge;
  logic [31:0] n_issue;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dram_write_merger #(
    .GBW(GBW), .DBW(DBW), .CSIZE(CSIZE), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .wi_rdy       (wi_rdy),
    .wi_ack       (wi_ack),
    .i_dramwa     (dramwa),
    .i_dramwd     (dramwd),
    .i_dramw_mask (dramw_mask),
    .i_flush      (flush),
    .dramw_rdy    (dramw_rdy),
    .dramw_ack    (dramw_ack),
    .o_dramwa     (o_addr),
    .o_dramwd     (o_data),
    .o_dramw_mask (o_mask),
    .o_idle       (o_idle)
`ifdef DRAMW_MERGE_STAT_EN
    ,
    .o_n_merge    (n_merge),
    .o_n_issue    (n_issue)
`endif
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input bit rdy, input logic [15:0] a, input line_t d,
                        input logic [7:0] m, input bit fl, input bit dk);
    wi_rdy = rdy; dramwa = a; dramwd = d; dramw_mask = m; flush = fl; dramw_ack = dk;
  endtask

  task automatic to_sample();
    @(negedge clk);
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  // Word k carries value k+1 where the mask selects it, zero elsewhere.
  function automatic line_t seq_line(input logic [7:0] m);
    line_t l;
    for (int k = 0; k < CSIZE; k++) l[k] = m[k] ? 16'(k + 1) : 16'h0;
    return l;
  endfunction

  typedef struct {
    bit          rst;
    bit          rdy;
    logic [15:0] a;
    logic [7:0]  m;
    bit          fl;
    bit          dk;
    bit          e_ack;
    bit          e_rdy;
    bit          e_idle;
    logic [15:0] e_a;
    logic [7:0]  e_m;
  } vec_t;

  function automatic vec_t mkv(bit r, bit rdy, logic [15:0] a, logic [7:0] m, bit fl, bit dk,
                               bit e_ack, bit e_rdy, bit e_idle, logic [15:0] e_a, logic [7:0] e_m);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.a = a; v.m = m; v.fl = fl; v.dk = dk;
    v.e_ack = e_ack; v.e_rdy = e_rdy; v.e_idle = e_idle; v.e_a = e_a; v.e_m = e_m;
    return v;
  endfunction

  // Reference model: one open line being collected and one line offered to DRAM.
  bit          m_open, m_out;
  int          m_idle;
  logic [15:0] m_addr, m_oaddr;
  line_t       m_data, m_odata;
  logic [7:0]  m_mask, m_omask;

  function automatic void m_clear();
    m_open = 0; m_out = 0; m_idle = 0; m_addr = '0; m_mask = '0; m_data = '0;
    m_oaddr = '0; m_omask = '0; m_odata = '0;
  endfunction

  function automatic void m_start(input logic [15:0] a, input line_t d, input logic [7:0] m);
    m_open = 1; m_addr = a; m_mask = m; m_idle = 0;
    for (int k = 0; k < CSIZE; k++) m_data[k] = m[k] ? d[k] : 16'h0;
  endfunction

  function automatic void m_add(input line_t d, input logic [7:0] m);
    for (int k = 0; k < CSIZE; k++) if (m[k]) m_data[k] = d[k];
    m_mask = m_mask | m;
    m_idle = 0;
  endfunction

  function automatic void m_close();
    m_out = 1; m_open = 0; m_oaddr = m_addr; m_odata = m_data; m_omask = m_mask;
  endfunction

  function automatic void m_step(input bit rdy, input logic [15:0] a, input line_t d,
                                 input logic [7:0] m, input bit fl, input bit dk);
    if (m_out) begin
      if (dk) begin
        m_out = 0;
        if (rdy && m != 0) m_start(a, d, m);
      end
    end else if (m_open) begin
      if (rdy && a == m_addr) begin
        m_add(d, m);
        if (m_mask == 8'hFF || fl) m_close();
      end else if (rdy || fl || m_mask == 8'hFF || m_idle == TIMEOUT) begin
        m_close();
      end else begin
        m_idle++;
      end
    end else if (rdy && m != 0) begin
      m_start(a, d, m);
    end
  endfunction

  vec_t        tbl[12];
  line_t       ld, ld2, le;
  logic [15:0] addrs[3];
  bit          p_v, fl, dk, e_ack;
  logic [15:0] p_a;
  line_t       p_d;
  logic [7:0]  p_m;
  int          sel;

  initial begin
    tbl[0]  = mkv(0, 1, 16'h40, 8'h0F, 0, 0, 1, 0, 1, 16'h0,  8'h00);
    tbl[1]  = mkv(0, 0, 16'h0,  8'h00, 0, 0, 0, 0, 0, 16'h0,  8'h00);
    tbl[2]  = mkv(0, 0, 16'h0,  8'h00, 0, 0, 0, 0, 0, 16'h0,  8'h00);
    tbl[3]  = mkv(0, 0, 16'h0,  8'h00, 0, 0, 0, 0, 0, 16'h0,  8'h00);
    tbl[4]  = mkv(0, 0, 16'h0,  8'h00, 0, 0, 0, 0, 0, 16'h0,  8'h00);
    tbl[5]  = mkv(0, 0, 16'h0,  8'h00, 0, 0, 0, 0, 0, 16'h0,  8'h00);
    tbl[6]  = mkv(0, 0, 16'h0,  8'h00, 0, 1, 0, 1, 0, 16'h40, 8'h0F);
    tbl[7]  = mkv(1, 1, 16'h40, 8'h0F, 0, 0, 0, 0, 1, 16'h0,  8'h00);
    tbl[8]  = mkv(0, 1, 16'h40, 8'h0F, 0, 0, 1, 0, 1, 16'h0,  8'h00);
    tbl[9]  = mkv(0, 1, 16'h40, 8'hF0, 0, 0, 1, 0, 0, 16'h0,  8'h00);
    tbl[10] = mkv(0, 0, 16'h0,  8'h00, 0, 1, 0, 1, 0, 16'h40, 8'hFF);
    tbl[11] = mkv(0, 0, 16'h0,  8'h00, 0, 0, 0, 0, 1, 16'h0,  8'h00);
    addrs[0] = 16'h40; addrs[1] = 16'h80; addrs[2] = 16'hC0;

    // Reset state, with an upstream request that must be ignored.
    rst = 1'b1;
    to_next();
    set_in(1, 16'h40, seq_line(8'hFF), 8'hFF, 1, 0);
    to_sample();
    chk("rst_wi_ack", wi_ack, 0);
    chk("rst_dramw_rdy", dramw_rdy, 0);
    chk("rst_o_idle", o_idle, 1);
    chk("rst_o_dramwa", o_addr, 0);
    chk("rst_o_dramw_mask", o_mask, 0);
    chk("rst_o_dramwd", o_data, 0);
    to_next();

    // Timeout issue, reset, then two halves merging into a full line.
    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].rst;
      set_in(tbl[i].rdy, tbl[i].a, seq_line(8'hFF), tbl[i].m, tbl[i].fl, tbl[i].dk);
      to_sample();
      chk($sformatf("tbl%0d_wi_ack", i), wi_ack, tbl[i].e_ack);
      chk($sformatf("tbl%0d_dramw_rdy", i), dramw_rdy, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_o_idle", i), o_idle, tbl[i].e_idle);
      if (tbl[i].e_rdy || tbl[i].rst) begin
        chk($sformatf("tbl%0d_addr", i), o_addr, tbl[i].e_a);
        chk($sformatf("tbl%0d_mask", i), o_mask, tbl[i].e_m);
        chk($sformatf("tbl%0d_data", i), o_data, seq_line(tbl[i].e_m));
      end
`ifdef DRAMW_MERGE_STAT_EN
      if (i == 11) begin
        chk("stat_n_merge", n_merge, 32'd1);
        chk("stat_n_issue", n_issue, 32'd1);
      end
`endif
      to_next();
    end

    // Overlapping masks: the later write wins, flush forces the issue.
    ld = '0; ld[0] = 16'h000A; ld[1] = 16'h000B; for (int k = 2; k < CSIZE; k++) ld[k] = 16'h5555;
    ld2 = '0; ld2[0] = 16'h0777; ld2[1] = 16'h000C;
    le = '0; le[0] = 16'h000A; le[1] = 16'h000C;
    set_in(1, 16'h40, ld, 8'h03, 0, 0);  to_sample(); chk("ovl_ack1", wi_ack, 1); to_next();
    set_in(1, 16'h40, ld2, 8'h02, 0, 0); to_sample(); chk("ovl_ack2", wi_ack, 1); to_next();
    set_in(0, 16'h0, '0, 8'h00, 1, 0);   to_sample(); chk("ovl_pre_rdy", dramw_rdy, 0); to_next();
    set_in(0, 16'h0, '0, 8'h00, 0, 1);   to_sample();
    chk("ovl_rdy", dramw_rdy, 1);
    chk("ovl_mask", o_mask, 8'h03);
    chk("ovl_data", o_data, le);
    to_next();
    set_in(0, 16'h0, '0, 8'h00, 0, 0);   to_sample(); chk("ovl_done_idle", o_idle, 1); to_next();

    // Different address while the first line waits on a stalled DRAM.
    ld = '0; ld[0] = 16'h1111;
    ld2 = '0; ld2[0] = 16'h2222;
    set_in(1, 16'h40, ld, 8'h01, 0, 0);  to_sample(); chk("stall_ack40", wi_ack, 1); to_next();
    set_in(1, 16'h80, ld2, 8'h01, 0, 0); to_sample(); chk("stall_noack80", wi_ack, 0); to_next();
    for (int c = 0; c < 3; c++) begin
      set_in(1, 16'h80, ld2, 8'h01, 0, 0); to_sample();
      chk("stall_wi_ack", wi_ack, 0);
      chk("stall_rdy", dramw_rdy, 1);
      chk("stall_addr", o_addr, 16'h40);
      chk("stall_state", dut.r_state, ST_ISSUE);
      to_next();
    end
    set_in(1, 16'h80, ld2, 8'h01, 0, 1); to_sample();
    chk("stall_ack80", wi_ack, 1);
    chk("stall_first_addr", o_addr, 16'h40);
    chk("stall_first_data", o_data, ld);
    to_next();
    set_in(0, 16'h0, '0, 8'h00, 1, 0);   to_sample(); chk("stall_collect80", dramw_rdy, 0); to_next();
    set_in(0, 16'h0, '0, 8'h00, 0, 1);   to_sample();
    chk("stall_second_rdy", dramw_rdy, 1);
    chk("stall_second_addr", o_addr, 16'h80);
    chk("stall_second_data", o_data, ld2);
    to_next();

    // Zero-mask drop in EMPTY, then reset while a line is being offered.
    set_in(1, 16'h40, seq_line(8'hFF), 8'h00, 0, 0); to_sample(); chk("zero_ack", wi_ack, 1); to_next();
    set_in(0, 16'h0, '0, 8'h00, 1, 0); to_sample();
    chk("zero_idle", o_idle, 1);
    chk("zero_no_issue", dramw_rdy, 0);
    to_next();
    set_in(1, 16'h40, seq_line(8'hFF), 8'hFF, 0, 0); to_sample(); chk("full_ack", wi_ack, 1); to_next();
    set_in(0, 16'h0, '0, 8'h00, 0, 0); to_sample(); chk("full_collect", dramw_rdy, 0); to_next();
    set_in(1, 16'h80, seq_line(8'hFF), 8'h01, 0, 0); to_sample();
    chk("full_issue_rdy", dramw_rdy, 1);
    rst = 1'b1;
    #1;
    chk("midrst_rdy", dramw_rdy, 0);
    chk("midrst_mask", o_mask, 8'h00);
    chk("midrst_idle", o_idle, 1);
    chk("midrst_wi_ack", wi_ack, 0);
    to_next();
    rst = 1'b0;
    set_in(0, 16'h0, '0, 8'h00, 0, 0); to_sample(); chk("postrst_rdy", dramw_rdy, 0); to_next();

    // Randomized traffic against the reference model.
    rst = 1'b1;
    to_next();
    rst = 1'b0;
    m_clear();
    p_v = 0; p_a = '0; p_d = '0; p_m = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!p_v && $urandom_range(3) != 0) begin
        p_v = 1;
        p_a = addrs[$urandom_range(2)];
        sel = $urandom_range(7);
        p_m = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom);
        p_d = {$urandom, $urandom, $urandom, $urandom};
      end
      fl = ($urandom_range(15) == 0);
      dk = m_out && ($urandom_range(2) != 0);
      set_in(p_v, p_a, p_d, p_m, fl, dk);
      to_sample();
      e_ack = m_out ? (p_v && dk) : m_open ? (p_v && p_a == m_addr) : p_v;
      chk("rnd_wi_ack", wi_ack, e_ack);
      chk("rnd_dramw_rdy", dramw_rdy, m_out);
      chk("rnd_o_idle", o_idle, !m_open && !m_out);
      if (m_out) begin
        chk("rnd_addr", o_addr, m_oaddr);
        chk("rnd_mask", o_mask, m_omask);
        chk("rnd_data", o_data, m_odata);
      end
      m_step(p_v, p_a, p_d, p_m, fl, dk);
      if (e_ack) p_v = 0;
      to_next();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
